// File: rtl/mac_seq_ctrl.sv
// mac_seq_ctrl: sequencer for the 8x8->24 MAC datapath.
// Pops operand pairs from two show-ahead operand FIFOs, drives MAC En/Clr,
// accumulates a programmable-length dot product, and presents the result on
// a valid/ready port.
//
// Optional feature macro: MAC_SEQ_OVF_EN adds the sticky ovf output and
// the accumulator wrap detector.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start, len          start pulse and vector length (sampled on accept)
//   a_empty, b_empty    operand FIFO empty flags
//   a_rden, b_rden      operand FIFO pops (combinational, equal every cycle)
//   mac_en, mac_clr     MAC control
//   mac_cout            MAC accumulator output
//   busy                high from accepted start until result transfer
//   res, res_vld, res_rdy  result port (valid/ready)
//   ovf                 sticky wrap flag (MAC_SEQ_OVF_EN only)
module mac_seq_ctrl #(
  parameter int unsigned LEN_W = 8,
  parameter int unsigned ACC_W = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             a_empty,
  input  logic             b_empty,
  output logic             a_rden,
  output logic             b_rden,
  output logic             mac_en,
  output logic             mac_clr,
  input  logic [ACC_W-1:0] mac_cout,
  output logic             busy,
  output logic [ACC_W-1:0] res,
  output logic             res_vld,
  input  logic             res_rdy
`ifdef MAC_SEQ_OVF_EN
  ,
  output logic             ovf
`endif
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLR   = 3'd1,
    ACCUM = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [LEN_W-1:0] cnt;
  logic [LEN_W-1:0] len_q;
  logic             fire;
  logic             accept;
  logic             cnt_inc;
  logic             res_cap;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and control outputs; all outputs are decoded from the
  // registered state, except the pops/En which follow the FIFO flags.
  always_comb begin
    state_nxt = state;
    a_rden    = 1'b0;
    b_rden    = 1'b0;
    mac_en    = 1'b0;
    mac_clr   = 1'b0;
    busy      = 1'b1;
    res_vld   = 1'b0;
    accept    = 1'b0;
    cnt_inc   = 1'b0;
    res_cap   = 1'b0;
    // Pop only when both FIFOs have data so they never desynchronise.
    fire      = !a_empty && !b_empty;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          accept    = 1'b1;
          state_nxt = CLR;
        end
      end
      CLR: begin
        mac_clr   = 1'b1;
        state_nxt = (len_q == '0) ? DRAIN : ACCUM;
      end
      ACCUM: begin
        a_rden = fire;
        b_rden = fire;
        mac_en = fire;
        if (fire) begin
          cnt_inc = 1'b1;
          if (cnt == len_q - LEN_W'(1)) begin
            state_nxt = DRAIN;
          end
        end
      end
      DRAIN: begin
        // MAC Cout already includes the last En here.
        res_cap   = 1'b1;
        state_nxt = DONE;
      end
      DONE: begin
        res_vld = 1'b1;
        if (res_rdy) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        busy      = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end

  // Length latch, pair counter and result capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q <= '0;
      cnt   <= '0;
      res   <= '0;
    end else begin
      if (accept) begin
        len_q <= len;
        cnt   <= '0;
      end else if (cnt_inc) begin
        cnt <= cnt + LEN_W'(1);
      end
      if (res_cap) begin
        res <= mac_cout;
      end
    end
  end

`ifdef MAC_SEQ_OVF_EN
  logic [ACC_W-1:0] prev;
  logic             en_d;

  // Wrap detector: Cout is compared one cycle after each En, when it has
  // absorbed the product; a decrease means the accumulator wrapped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev <= '0;
      en_d <= 1'b0;
      ovf  <= 1'b0;
    end else begin
      en_d <= mac_en;
      if (mac_clr) begin
        prev <= '0;
      end else if (en_d) begin
        prev <= mac_cout;
        if (mac_cout < prev) begin
          ovf <= 1'b1;
        end
      end
      if (accept) begin
        ovf <= 1'b0;
      end
    end
  end
`endif

endmodule

// File: doc/mac_seq_ctrl.md
Name: mac_seq_ctrl

Overview:
- Sequencer for the 8x8->24 MAC datapath. Pops operand pairs from two show-ahead (first-word-fall-through) operand FIFOs and drives MAC En/Clr.
- Accumulates a programmable-length dot product, then presents the 24-bit result on a valid/ready output port.
- Sits between the operand FIFOs and the MAC. It is the only agent allowed to drive MAC En/Clr.

Parameters:
- LEN_W, 8, width of the vector-length input; maximum length is 2^LEN_W-1.
- ACC_W, 24, width of the MAC accumulator and result; must equal the MAC Cout width.

Ports:
- clk  in  1  system clock, rising-edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  pulse; begin a dot product; ignored while busy=1
- len  in  LEN_W  number of operand pairs; sampled when start is accepted
- a_empty  in  1  operand-A FIFO empty
- b_empty  in  1  operand-B FIFO empty
- a_rden  out  1  pop operand-A FIFO
- b_rden  out  1  pop operand-B FIFO
- mac_en  out  1  to MAC En
- mac_clr  out  1  to MAC Clr
- mac_cout  in  ACC_W  from MAC Cout
- busy  out  1  high from accepted start until result handshake completes
- res  out  ACC_W  captured result, stable while res_vld=1
- res_vld  out  1  result valid
- res_rdy  in  1  consumer accepts result
- ovf  out  1  sticky overflow flag; only present when MAC_SEQ_OVF_EN is defined

Behaviour:
- Reset (async, rst_n=0): state=IDLE, cnt=0, len_q=0, res=0.
- Reset values of outputs: all outputs 0.
- A reset mid-operation abandons the operation. Any pops already taken are not replayed.
- FSM states: IDLE, CLR, ACCUM, DRAIN, DONE.
- IDLE:
  - busy=0.
  - When start=1, latch len_q<=len, cnt<=0, then go to CLR.
- CLR:
  - mac_clr=1 for exactly one cycle; busy=1.
  - Next state is DRAIN if len_q==0, else ACCUM.
- ACCUM:
  - fire = !a_empty && !b_empty. Combinational: a_rden=b_rden=mac_en=fire.
  - Nothing is popped unless both FIFOs are non-empty, so the two FIFOs never desynchronise.
  - On fire: cnt<=cnt+1. If cnt==len_q-1, go to DRAIN.
  - Stall cycles (either FIFO empty) hold all state.
- DRAIN:
  - One cycle; mac_cout already reflects the final En.
  - res<=mac_cout, then go to DONE.
  - For len_q==0, res=0 because of the preceding Clr.
- DONE:
  - res_vld=1; res is held.
  - When res_rdy=1, go to IDLE; res_vld drops the next cycle.
  - res is not cleared; it keeps its last value.
- Handshake and start rules:
  - A result transfers on a cycle with res_vld && res_rdy.
  - res_rdy is ignored when res_vld=0.
  - start in the same cycle as the result transfer is ignored. A new start is accepted only when the state is IDLE.
- mac_en and mac_clr are never both high.
- Latency with both FIFOs never empty: start sampled at edge 0, first mac_en in cycle 2, res_vld high from cycle len+3.
- Width: with the default LEN_W=8 the maximum sum is 255*255*255=16,581,375 < 2^24, so it cannot overflow. Larger LEN_W may wrap; the accumulator wraps modulo 2^ACC_W, matching the MAC.

Optional Feature:
- Macro: MAC_SEQ_OVF_EN.
- When defined:
  - The ovf port and logic exist.
  - The block keeps prev=mac_cout; prev is cleared in CLR and updated in the cycle after each mac_en.
  - If the new mac_cout < prev (unsigned), ovf<=1.
  - ovf is sticky until the next accepted start or reset; it is valid alongside res_vld.
- When not defined: no ovf port and no comparison logic. Behaviour is otherwise identical.

Test Plan:
- Reset mid-ACCUM (len=8, after 3 pops) -> all outputs 0 the same cycle; after release, busy=0 and state is IDLE; a new start with len=2 runs cleanly.
- len=4, A={3,3,3,3}, B={4,4,4,4}, FIFOs preloaded, res_rdy=1 -> mac_clr one cycle, 4 consecutive mac_en, res=48, res_vld first seen 7 cycles after start, busy low the cycle after the transfer.
- len=3, A={255,1,2}, B={255,1,3}; B FIFO empty for 5 cycles after the first pop -> no pops while empty, a_rden==b_rden every cycle, res=65032.
- len=0 -> mac_clr pulse, zero mac_en, res=0 valid.
- Back-to-back dot products; res_rdy held low 10 cycles; start pulsed during DONE -> res/res_vld stable and start ignored; second start after IDLE gives a fresh sum with no carry-over from the previous result.
- MAC_SEQ_OVF_EN, LEN_W=10, len=300, all operands 255 -> ovf=1 with res=(300*65025) mod 2^24 = 2,730,284; next start clears ovf; with the macro undefined the port is absent.
